mem_arbiter: RTL and testbench

- Single-port memory arbiter that is the producer of the ihit/dhit signals consumed by the hazard unit.
- Accepts the instruction-fetch request and the data (load/store) request from the pipelined datapath, serialises them onto one RAM port, and returns one-cycle hit pulses with load data.
- Data requests have priority over fetches. A watchdog flags a stalled RAM.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and memory-arbiter state encoding.
// Pure type/constant package; no logic, no timing.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of datapath-side and RAM-side arbiter signals with arbiter and bench views.
// Wires only; timing and handshake are defined by mem_arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  halt;
  logic  ihit;
  logic  dhit;
  word_t iload;
  word_t dload;
  logic  ram_ren;
  logic  ram_wen;
  word_t ram_addr;
  word_t ram_store;
  word_t ram_load;
  logic  ram_ready;
  logic  busy_err;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ram_load, ram_ready,
    output ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, busy_err
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ram_load, ram_ready,
    input  ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, busy_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises data and fetch requests onto one RAM port, data first; min 3 cycles per access.
// Requests are held until their hit pulse; RAM stalls via ram_ready, watched by a sticky watchdog.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  input  logic  halt,
  output logic  ihit,
  output logic  dhit,
  output word_t iload,
  output word_t dload,
  output logic  ram_ren,
  output logic  ram_wen,
  output word_t ram_addr,
  output word_t ram_store,
  input  word_t ram_load,
  input  logic  ram_ready,
  output logic  busy_err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_t state;
  logic [7:0] wd_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wd_cnt    <= '0;
      busy_err  <= 1'b0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      iload     <= '0;
      dload     <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          // A store wins over a load if both strobes are up.
          if (dREN || dWEN) begin
            state     <= DACC;
            ram_addr  <= daddr;
            ram_store <= dstore;
            ram_wen   <= dWEN;
            ram_ren   <= !dWEN;
            wd_cnt    <= '0;
          end else if (iREN && !halt) begin
            state     <= IACC;
            ram_addr  <= iaddr;
            ram_store <= '0;
            ram_wen   <= 1'b0;
            ram_ren   <= 1'b1;
            wd_cnt    <= '0;
          end
        end
        DACC, IACC: begin
          if (ram_ready) begin
            if (state == DACC) begin
              if (!ram_wen) dload <= ram_load;
              dhit  <= 1'b1;
              state <= DRESP;
            end else begin
              iload <= ram_load;
              ihit  <= 1'b1;
              state <= IRESP;
            end
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
          end else begin
            // Keep waiting on a stalled RAM; only flag it.
            if (wd_cnt != 8'hFF) wd_cnt <= wd_cnt + 8'd1;
            if (wd_cnt == TMO_LAST) busy_err <= 1'b1;
          end
        end
        DRESP, IRESP: state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short watchdog (TIMEOUT=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   n_chk = 0;
  int   n_err = 0;
  int   cnt_a;
  int   cnt_b;

  mem_arbiter_if mif ();

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .iREN      (mif.iREN),
    .iaddr     (mif.iaddr),
    .dREN      (mif.dREN),
    .dWEN      (mif.dWEN),
    .daddr     (mif.daddr),
    .dstore    (mif.dstore),
    .halt      (mif.halt),
    .ihit      (mif.ihit),
    .dhit      (mif.dhit),
    .iload     (mif.iload),
    .dload     (mif.dload),
    .ram_ren   (mif.ram_ren),
    .ram_wen   (mif.ram_wen),
    .ram_addr  (mif.ram_addr),
    .ram_store (mif.ram_store),
    .ram_load  (mif.ram_load),
    .ram_ready (mif.ram_ready),
    .busy_err  (mif.busy_err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    RST           = 1'b1;
    mif.iREN      = 1'b0;
    mif.iaddr     = '0;
    mif.dREN      = 1'b0;
    mif.dWEN      = 1'b0;
    mif.daddr     = '0;
    mif.dstore    = '0;
    mif.halt      = 1'b0;
    mif.ram_load  = '0;
    mif.ram_ready = 1'b0;
    step();
    step();
    RST = 1'b0;

    // Reset state
    chk("rst_ihit", 32'(mif.ihit), 0);
    chk("rst_dhit", 32'(mif.dhit), 0);
    chk("rst_ren", 32'(mif.ram_ren), 0);
    chk("rst_wen", 32'(mif.ram_wen), 0);
    chk("rst_addr", mif.ram_addr, 0);
    chk("rst_busy", 32'(mif.busy_err), 0);
    chk("rst_iload", mif.iload, 0);
    chk("rst_dload", mif.dload, 0);

    // Single fetch, RAM ready in first access cycle
    mif.iREN = 1'b1; mif.iaddr = 32'h40;
    step();
    chk("f1_ren", 32'(mif.ram_ren), 1);
    chk("f1_wen", 32'(mif.ram_wen), 0);
    chk("f1_addr", mif.ram_addr, 32'h40);
    chk("f1_ihit_early", 32'(mif.ihit), 0);
    mif.ram_ready = 1'b1; mif.ram_load = 32'h8C010004;
    step();
    chk("f1_ihit", 32'(mif.ihit), 1);
    chk("f1_iload", mif.iload, 32'h8C010004);
    chk("f1_ren_off", 32'(mif.ram_ren), 0);
    mif.iREN = 1'b0; mif.ram_ready = 1'b0;
    step();
    chk("f1_ihit_once", 32'(mif.ihit), 0);
    chk("f1_iload_hold", mif.iload, 32'h8C010004);

    // Simultaneous fetch and load: data first
    mif.iREN = 1'b1; mif.iaddr = 32'h44; mif.dREN = 1'b1; mif.daddr = 32'h100;
    step();
    chk("pri_daddr", mif.ram_addr, 32'h100);
    chk("pri_dren", 32'(mif.ram_ren), 1);
    mif.ram_ready = 1'b1; mif.ram_load = 32'h11111111;
    step();
    chk("pri_dhit", 32'(mif.dhit), 1);
    chk("pri_ihit_excl", 32'(mif.ihit), 0);
    chk("pri_dload", mif.dload, 32'h11111111);
    mif.dREN = 1'b0; mif.ram_ready = 1'b0;
    step();
    chk("pri_idle_dhit", 32'(mif.dhit), 0);
    chk("pri_idle_ren", 32'(mif.ram_ren), 0);
    step();
    chk("pri_iaddr", mif.ram_addr, 32'h44);
    chk("pri_iren", 32'(mif.ram_ren), 1);
    mif.ram_ready = 1'b1; mif.ram_load = 32'h22222222;
    step();
    chk("pri_ihit", 32'(mif.ihit), 1);
    chk("pri_dhit_excl", 32'(mif.dhit), 0);
    chk("pri_iload", mif.iload, 32'h22222222);
    mif.iREN = 1'b0; mif.ram_ready = 1'b0;
    step();

    // Store with RAM ready after 5 wait cycles
    mif.dWEN = 1'b1; mif.daddr = 32'h200; mif.dstore = 32'hDEADBEEF;
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (mif.ram_wen) cnt_a++;
      if (mif.ram_ren) cnt_b++;
      if (k == 1) begin
        chk("st_addr", mif.ram_addr, 32'h200);
        chk("st_data", mif.ram_store, 32'hDEADBEEF);
      end
      if (k == 3) chk("st_busy_lo", 32'(mif.busy_err), 0);
      if (k == 5) chk("st_busy_hi", 32'(mif.busy_err), 1);
      chk("st_nohit", 32'(mif.dhit), 0);
      if (k == 6) begin
        mif.ram_ready = 1'b1; mif.ram_load = 32'hBAD0BAD0;
      end
    end
    chk("st_wen_cycles", 32'(cnt_a), 6);
    chk("st_ren_cycles", 32'(cnt_b), 0);
    step();
    chk("st_dhit", 32'(mif.dhit), 1);
    chk("st_dload_kept", mif.dload, 32'h11111111);
    chk("st_wen_off", 32'(mif.ram_wen), 0);
    mif.dWEN = 1'b0; mif.ram_ready = 1'b0;
    step();
    chk("st_dhit_once", 32'(mif.dhit), 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("st_busy_clr", 32'(mif.busy_err), 0);

    // Halt blocks fetches but not data
    mif.halt = 1'b1; mif.iREN = 1'b1; mif.iaddr = 32'h60;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (mif.ram_ren) cnt_a++;
      if (mif.ihit) cnt_b++;
    end
    chk("halt_ren", 32'(cnt_a), 0);
    chk("halt_ihit", 32'(cnt_b), 0);
    mif.dREN = 1'b1; mif.daddr = 32'h300;
    step();
    chk("halt_daddr", mif.ram_addr, 32'h300);
    chk("halt_dren", 32'(mif.ram_ren), 1);
    mif.ram_ready = 1'b1; mif.ram_load = 32'h33333333;
    step();
    chk("halt_dhit", 32'(mif.dhit), 1);
    chk("halt_dload", mif.dload, 32'h33333333);
    mif.dREN = 1'b0; mif.iREN = 1'b0; mif.halt = 1'b0; mif.ram_ready = 1'b0;
    step();

    // Watchdog during a stalled fetch
    mif.iREN = 1'b1; mif.iaddr = 32'h80;
    cnt_a = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (mif.ram_ren) cnt_a++;
      if (k == 3) chk("wd_busy_lo", 32'(mif.busy_err), 0);
      if (k == 5) chk("wd_busy_hi", 32'(mif.busy_err), 1);
    end
    chk("wd_ren_cycles", 32'(cnt_a), 6);
    mif.ram_ready = 1'b1; mif.ram_load = 32'h55555555;
    step();
    chk("wd_ihit", 32'(mif.ihit), 1);
    chk("wd_iload", mif.iload, 32'h55555555);
    mif.iREN = 1'b0; mif.ram_ready = 1'b0;
    step();
    step();
    chk("wd_busy_sticky", 32'(mif.busy_err), 1);

    // Reset in the middle of a stalled load
    RST = 1'b1;
    step();
    RST = 1'b0;
    mif.dREN = 1'b1; mif.daddr = 32'h400;
    for (int k = 1; k <= 5; k++) step();
    chk("ra_ren_wait", 32'(mif.ram_ren), 1);
    chk("ra_busy_pre", 32'(mif.busy_err), 1);
    RST = 1'b1;
    step();
    chk("ra_ren", 32'(mif.ram_ren), 0);
    chk("ra_dhit", 32'(mif.dhit), 0);
    chk("ra_busy", 32'(mif.busy_err), 0);
    chk("ra_addr", mif.ram_addr, 0);
    RST = 1'b0; mif.dREN = 1'b0;
    step();
    chk("ra_idle_dhit", 32'(mif.dhit), 0);
    chk("ra_idle_ren", 32'(mif.ram_ren), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
